wallace_mul_pipe: RTL and testbench

//  Parametrised, pipelined Wallace-tree multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/wallace_mul_pipe_if.sv | 25 ++
 rtl/wallace_mul_pipe.sv | 153 +++++++++++++++
 tb/tb_wallace_mul_pipe.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wallace_mul_pipe_if.sv
// wallace_mul_pipe_if: operand/result handshake bundle for wallace_mul_pipe.
//   in_valid/in_ready/a/b     operand side (master drives in_valid, a, b)
//   out_valid/out_ready/prod  result side (master drives out_ready)
// The multiplier connects through the slave modport, the issuer through master.
interface wallace_mul_pipe_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] prod;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   clk  clock, rising edge
//   rst  synchronous reset, active high: clears all stage valids and prod
//   bus  slave side of wallace_mul_pipe_if (operands in, product out, valid/ready both sides)
// Partial products are reduced by 3:2 CSA layers spread over stages 1..STAGES-1;
// the last stage does the carry-propagate add into the prod register. With
// STAGES=1 the whole tree and CPA sit in front of the single register.
// SIGNED=1 uses Baugh-Wooley partial products (result is two's complement).
module wallace_mul_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    wallace_mul_pipe_if.slave bus
);
    localparam int PW   = 2 * WIDTH;
    localparam int NPP  = WIDTH + ((SIGNED != 0) ? 1 : 0);   // extra row holds the BW constants
    localparam int NW   = 3 * ((NPP + 2) / 3);               // working rows, padded to whole CSA groups
    localparam int NCSA = (STAGES > 1) ? STAGES - 1 : 1;     // stages that carry CSA layers
    localparam int RQ   = (STAGES > 1) ? STAGES - 1 : 1;

    // Row count after a number of CSA layers: every full group of 3 becomes 2.
    function automatic int rows_after(input int n, input int layers);
        int r;
        r = n;
        for (int l = 0; l < layers; l++) r = r - r / 3;
        return r;
    endfunction

    function automatic int num_layers(input int n);
        int r;
        int cnt;
        r   = n;
        cnt = 0;
        while (r > 2) begin
            r   = r - r / 3;
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    localparam int NL = num_layers(NPP);

    typedef logic [NPP-1:0][PW-1:0] rows_t;
    typedef logic [NW-1:0][PW-1:0]  work_t;

    rows_t             pp;
    rows_t             stg_red [1:STAGES];
    rows_t             rows_q  [1:RQ];
    logic [STAGES:1]   vld_pipe;
    logic [STAGES:0]   vld_src;
    logic [STAGES+1:1] adv;
    logic [PW-1:0]     cpa;
    logic [PW-1:0]     prod_q;

    // Partial products; in signed mode the cross terms touching exactly one
    // MSB are inverted and the correction constant lives in its own row.
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (bus.a[j] & bus.b[i]) ^
                             ((SIGNED != 0) && ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (SIGNED != 0) begin
            pp[NPP-1][WIDTH] = 1'b1;
            pp[NPP-1][PW-1]  = 1'b1;
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        // Layers [LO,HI) are evaluated in front of this stage's register.
        localparam int LO = (k <= NCSA) ? (NL * (k - 1)) / NCSA : NL;
        localparam int HI = (k <= NCSA) ? (NL * k) / NCSA : NL;

        rows_t src;
        work_t cur;
        work_t nxt;
        int    g;

        if (k == 1) begin : g_src
            assign src = pp;
        end else begin : g_src
            assign src = rows_q[k-1];
        end

        // Rows at or beyond the live count are always zero, so the partial
        // group left over after the full ones can be copied unconditionally.
        always_comb begin
            cur = '0;
            cur[NPP-1:0] = src;
            nxt = '0;
            g   = 0;
            for (int l = LO; l < HI; l++) begin
                g   = rows_after(NPP, l) / 3;
                nxt = '0;
                for (int i = 0; i < NW / 3; i++) begin
                    if (i < g) begin
                        nxt[2*i]   = cur[3*i] ^ cur[3*i+1] ^ cur[3*i+2];
                        nxt[2*i+1] = ((cur[3*i] & cur[3*i+1]) |
                                      (cur[3*i+1] & cur[3*i+2]) |
                                      (cur[3*i] & cur[3*i+2])) << 1;
                    end else if (i == g) begin
                        nxt[2*i]   = cur[3*i];
                        nxt[2*i+1] = cur[3*i+1];
                    end
                end
                cur = nxt;
            end
        end

        assign stg_red[k] = cur[NPP-1:0];
    end

    assign cpa = stg_red[STAGES][0] + stg_red[STAGES][1];

    // Stage k moves when it is empty or its successor moves; the chain is
    // combinational from out_ready so bubbles collapse under a stalled output.
    assign vld_src = {vld_pipe, bus.in_valid};

    always_comb begin
        adv = '0;
        adv[STAGES+1] = bus.out_ready;
        for (int k = STAGES; k >= 1; k--) adv[k] = !vld_pipe[k] || adv[k+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            prod_q   <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (adv[k]) vld_pipe[k] <= vld_src[k-1];
            end
            if (adv[STAGES] && vld_src[STAGES-1]) prod_q <= cpa;
        end
    end

    // Intermediate carry-save rows carry no reset; they are only observed
    // behind a set valid bit.
    always_ff @(posedge clk) begin
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k] && vld_src[k-1]) rows_q[k] <= stg_red[k];
        end
    end

    assign bus.in_ready  = adv[1];
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.prod      = prod_q;
endmodule

// File: tb/tb_wallace_mul_pipe.sv
module tb_wallace_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wallace_mul_pipe_if #(.WIDTH(4))  bu ();
    wallace_mul_pipe_if #(.WIDTH(4))  bs ();
    wallace_mul_pipe_if #(.WIDTH(16)) bw ();

    wallace_mul_pipe #(.WIDTH(4),  .STAGES(2), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(bu.slave));
    wallace_mul_pipe #(.WIDTH(4),  .STAGES(2), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
    wallace_mul_pipe #(.WIDTH(16), .STAGES(4), .SIGNED(1)) dut_w (.clk(clk), .rst(rst), .bus(bw.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          acc;
    } ent_t;

    ent_t       q4[$];
    ent_t       qw[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    bit         tk;
    bit         stalled = 1'b0;
    logic [7:0] held;
    int         sent;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mul_u(input logic [3:0] a, input logic [3:0] b);
        return {4'b0, a} * {4'b0, b};
    endfunction

    function automatic logic [7:0] mul_s(input logic [3:0] a, input logic [3:0] b);
        return {{4{a[3]}}, a} * {{4{b[3]}}, b};
    endfunction

    function automatic logic [31:0] mul_w(input logic [15:0] a, input logic [15:0] b);
        return {{16{a[15]}}, a} * {{16{b[15]}}, b};
    endfunction

    task automatic drv4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ordy);
        bu.in_valid = v; bu.a = a; bu.b = b; bu.out_ready = ordy;
        bs.in_valid = v; bs.a = a; bs.b = b; bs.out_ready = ordy;
    endtask

    // One cycle on the two 4-bit DUTs: drive at negedge, check, then clock.
    task automatic step4(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ordy, input bit lat, output bit took);
        ent_t e;
        drv4(v, a, b, ordy);
        #1;
        if (stalled) begin
            chk("stall_prod", bu.prod, held);
            chk("stall_valid", bu.out_valid, 1'b1);
        end
        chk("in_ready", bu.in_ready, (q4.size() < 2) || ordy);
        chk("s_in_ready", bs.in_ready, (q4.size() < 2) || ordy);
        if (bu.out_valid && ordy) begin
            if (q4.size() == 0) begin
                chk("spurious", bu.out_valid, 1'b0);
            end else begin
                e = q4.pop_front();
                chk("prod_u", bu.prod, mul_u(e.a[3:0], e.b[3:0]));
                chk("prod_s", bs.prod, mul_s(e.a[3:0], e.b[3:0]));
                chk("s_valid", bs.out_valid, 1'b1);
                if (lat) chk("latency", cyc - e.acc, 2);
            end
        end
        stalled = bu.out_valid && !ordy;
        held    = bu.prod;
        took    = v && bu.in_ready;
        if (took) q4.push_back('{a: {12'b0, a}, b: {12'b0, b}, acc: cyc});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic stepw(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ordy, input bit lat, output bit took);
        ent_t e;
        bw.in_valid = v; bw.a = a; bw.b = b; bw.out_ready = ordy;
        #1;
        if (bw.out_valid && ordy) begin
            if (qw.size() == 0) begin
                chk("w_spurious", bw.out_valid, 1'b0);
            end else begin
                e = qw.pop_front();
                chk("w_prod", bw.prod, mul_w(e.a, e.b));
                if (lat) chk("w_latency", cyc - e.acc, 4);
            end
        end
        took = v && bw.in_ready;
        if (took) qw.push_back('{a: a, b: b, acc: cyc});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drv4(1'b0, 4'h0, 4'h0, 1'b0);
        bw.in_valid = 1'b0; bw.a = '0; bw.b = '0; bw.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid_u", bu.out_valid, 1'b0);
        chk("rst_prod_u", bu.prod, 8'h00);
        chk("rst_prod_s", bs.prod, 8'h00);
        chk("rst_in_ready", bu.in_ready, 1'b1);
        chk("rst_valid_w", bw.out_valid, 1'b0);
        rst = 1'b0;

        // Single max-value product and its latency.
        step4(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, tk);
        chk("t1_early", bu.out_valid, 1'b0);
        step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, tk);
        chk("t1_valid", bu.out_valid, 1'b1);
        chk("t1_prod_u", bu.prod, 8'hE1);
        chk("t1_prod_s", bs.prod, 8'h01);
        step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, tk);

        // Exhaustive back-to-back stream, both signedness modes.
        for (int i = 0; i < 256; i++) step4(1'b1, 4'(i >> 4), 4'(i), 1'b1, 1'b1, tk);
        repeat (3) step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, tk);
        chk("t2_drained", q4.size(), 0);
        step4(1'b1, 4'h8, 4'h8, 1'b1, 1'b1, tk);
        step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, tk);
        chk("t2_s_8x8", bs.prod, 8'h40);
        chk("t2_u_8x8", bu.prod, 8'h40);
        step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, tk);

        // Ten pairs with a 5-cycle output stall in the middle.
        sent = 0;
        for (int t = 0; t < 22; t++) begin
            step4(sent < 10, 4'(sent * 3 + 1), 4'(15 - sent), !(t >= 3 && t < 8), 1'b0, tk);
            if (tk) sent++;
        end
        chk("t3_sent", sent, 10);
        chk("t3_drained", q4.size(), 0);

        // Bubble collapse: second pair still accepted with the output stalled.
        step4(1'b1, 4'h2, 4'h3, 1'b0, 1'b0, tk);
        chk("t4_first", tk, 1'b1);
        step4(1'b1, 4'h4, 4'h5, 1'b0, 1'b0, tk);
        chk("t4_second", tk, 1'b1);
        step4(1'b1, 4'h6, 4'h7, 1'b0, 1'b0, tk);
        chk("t4_full", tk, 1'b0);
        repeat (4) step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, tk);
        chk("t4_drained", q4.size(), 0);

        // Reset with two pairs in flight; they must never come out.
        step4(1'b1, 4'h3, 4'h5, 1'b0, 1'b0, tk);
        step4(1'b1, 4'h6, 4'h7, 1'b0, 1'b0, tk);
        rst = 1'b1;
        drv4(1'b0, 4'h0, 4'h0, 1'b1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        q4.delete();
        stalled = 1'b0;
        drv4(1'b0, 4'h0, 4'h0, 1'b0);
        #1;
        chk("t5_valid", bu.out_valid, 1'b0);
        chk("t5_prod_u", bu.prod, 8'h00);
        chk("t5_prod_s", bs.prod, 8'h00);
        chk("t5_in_ready", bu.in_ready, 1'b1);
        repeat (4) step4(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, tk);

        // Wide signed pipe: latency on an idle pipe, then random traffic.
        stepw(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, tk);
        repeat (4) stepw(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, tk);
        chk("w_lat_drained", qw.size(), 0);
        stepw(1'b1, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1, tk);
        repeat (4) stepw(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, tk);
        sent = 0;
        for (int t = 0; t < 40000 && sent < 10000; t++) begin
            stepw($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  $urandom_range(0, 9) < 7, 1'b0, tk);
            if (tk) sent++;
        end
        chk("w_sent", sent, 10000);
        repeat (8) stepw(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, tk);
        chk("w_drained", qw.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
